sample_capture_ctrl: RTL

Sequences sample capture into the 512x16 dual-port sample buffer through its second (fabric-side) port; the HPS reads the first port over Avalon.
Accepts a stream of 16-bit samples and optionally waits for a trigger edge.
Writes either a single-shot block of programmable length or a continuous ping-pong ring with half-buffer interrupts.
Reports progress, completion and overflow to the software control registers.

---
 rtl/sample_capture_ctrl_if.sv | 24 ++
 rtl/sample_capture_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sample_capture_ctrl_if.sv
`default_nettype none
// =============================================================================
// sample_capture_ctrl_if : write bus into the sample buffer's fabric-side port
// Rev 1.0
// =============================================================================
interface sample_capture_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0]   buf_address;
  logic                buf_chipselect;
  logic                buf_write;
  logic [DATA_W/8-1:0] buf_byteenable;
  logic [DATA_W-1:0]   buf_writedata;

  modport master (
    output buf_address, buf_chipselect, buf_write, buf_byteenable, buf_writedata
  );

  modport slave (
    input buf_address, buf_chipselect, buf_write, buf_byteenable, buf_writedata
  );
endinterface
`default_nettype wire

// File: rtl/sample_capture_ctrl.sv
`default_nettype none
// =============================================================================
// sample_capture_ctrl : single-shot / ping-pong sample capture into a buffer
// Rev 1.0
// =============================================================================
module sample_capture_ctrl #(
  parameter int ADDR_W          = 9,
  parameter int DATA_W          = 16,
  parameter bit HALF_TIMEOUT_EN = 1'b1
) (
  input  wire                   clk,
  input  wire                   reset,
  input  wire                   cfg_start,
  input  wire                   cfg_stop,
  input  wire  [ADDR_W:0]       cfg_length,
  input  wire                   cfg_continuous,
  input  wire                   cfg_trig_en,
  input  wire                   trig_in,
  input  wire                   smp_valid,
  input  wire  [DATA_W-1:0]     smp_data,
  input  wire                   half_ack,
  sample_capture_ctrl_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  irq_half,
  output logic                  half_id,
  output logic [ADDR_W:0]       wr_count
);

  localparam logic [ADDR_W:0]     c_DEPTH     = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W-1:0]   c_HALF_LAST = ADDR_W'(2**(ADDR_W-1) - 1);
  localparam logic [ADDR_W-1:0]   c_LAST      = {ADDR_W{1'b1}};
  localparam logic [DATA_W/8-1:0] c_BE_ALL    = {(DATA_W/8){1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic                r_trig_prev;
  logic                r_cont;
  logic [ADDR_W:0]     r_len;
  logic [ADDR_W:0]     r_count;
  logic [ADDR_W-1:0]   r_ptr;
  logic [1:0]          r_pending;
  logic                r_done;
  logic                r_overflow;
  logic                r_irq_half;
  logic                r_half_id;

  logic [ADDR_W-1:0]   r_buf_address;
  logic                r_buf_write;
  logic [DATA_W/8-1:0] r_buf_byteenable;
  logic [DATA_W-1:0]   r_buf_writedata;

  logic                w_trig_edge;
  logic                w_start;
  logic [ADDR_W:0]     w_len_clamped;
  logic                w_accept;
  logic                w_ovf;
  logic                w_write;
  logic                w_last;
  logic                w_stop;
  logic [1:0]          w_pend_set;
  logic [1:0]          w_pend_clr;

  assign w_trig_edge   = trig_in & ~r_trig_prev;
  // A start colliding with a stop is dropped, and only counts from IDLE/DONE.
  assign w_start       = cfg_start & ~cfg_stop &
                         ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_len_clamped = ((cfg_length == '0) || (cfg_length > c_DEPTH)) ?
                         c_DEPTH : cfg_length;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_stop       = 1'b0;
    w_ovf        = 1'b0;
    w_write      = 1'b0;
    w_last       = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start) begin
          w_next_state = cfg_trig_en ? S_ARMED : S_CAPTURE;
        end
      end
      S_ARMED: begin
        if (cfg_stop) begin
          w_stop       = 1'b1;
          w_next_state = S_DONE;
        end else if (w_trig_edge) begin
          // The sample on the edge cycle is the first one kept.
          w_accept     = smp_valid;
          w_next_state = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (cfg_stop) begin
          w_stop       = 1'b1;
          w_next_state = S_DONE;
        end else begin
          w_accept = smp_valid;
        end
      end
      default: w_next_state = S_IDLE;
    endcase

    w_ovf   = w_accept & r_cont & HALF_TIMEOUT_EN & r_pending[r_ptr[ADDR_W-1]];
    w_write = w_accept & ~w_ovf;
    w_last  = w_write & ~r_cont & ((r_count + (ADDR_W+1)'(1)) == r_len);

    if (w_ovf || w_last) begin
      w_next_state = S_DONE;
    end
  end

  assign w_pend_set[0] = w_write & r_cont & (r_ptr == c_HALF_LAST);
  assign w_pend_set[1] = w_write & r_cont & (r_ptr == c_LAST);
  assign w_pend_clr    = half_ack ? (r_half_id ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_trig_prev      <= 1'b0;
      r_cont           <= 1'b0;
      r_len            <= '0;
      r_count          <= '0;
      r_ptr            <= '0;
      r_pending        <= '0;
      r_done           <= 1'b0;
      r_overflow       <= 1'b0;
      r_irq_half       <= 1'b0;
      r_half_id        <= 1'b0;
      r_buf_address    <= '0;
      r_buf_write      <= 1'b0;
      r_buf_byteenable <= '0;
      r_buf_writedata  <= '0;
    end else begin
      r_trig_prev <= trig_in;
      r_buf_write <= w_write;
      r_irq_half  <= |w_pend_set;

      if (w_start) begin
        r_len      <= w_len_clamped;
        r_cont     <= cfg_continuous;
        r_count    <= '0;
        r_ptr      <= '0;
        r_pending  <= '0;
        r_done     <= 1'b0;
        r_overflow <= 1'b0;
      end else begin
        // A set on the same cycle as an ack of that half leaves it set.
        r_pending <= (r_pending & ~w_pend_clr) | w_pend_set;
      end

      if (w_write) begin
        r_buf_address    <= r_ptr;
        r_buf_writedata  <= smp_data;
        r_buf_byteenable <= c_BE_ALL;
        r_ptr            <= r_ptr + ADDR_W'(1);
        if (r_count != c_DEPTH) begin
          r_count <= r_count + (ADDR_W+1)'(1);
        end
      end

      if (w_pend_set[1]) begin
        r_half_id <= 1'b1;
      end else if (w_pend_set[0]) begin
        r_half_id <= 1'b0;
      end

      if (w_stop || w_ovf || w_last) begin
        r_done <= 1'b1;
      end
      if (w_ovf) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.buf_address    = r_buf_address;
  assign bus.buf_chipselect = r_buf_write;
  assign bus.buf_write      = r_buf_write;
  assign bus.buf_byteenable = r_buf_byteenable;
  assign bus.buf_writedata  = r_buf_writedata;

  assign busy     = (r_state == S_ARMED) | (r_state == S_CAPTURE);
  assign done     = r_done;
  assign overflow = r_overflow;
  assign irq_half = r_irq_half;
  assign half_id  = r_half_id;
  assign wr_count = r_count;

endmodule
`default_nettype wire
